// File: rtl/vram_port_arbiter.sv
// Arbiter for the video-side port of the frame-buffer block RAM.
// Video has fixed priority; an aging counter force-grants the aux master after MAX_WAIT lost cycles.
module vram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_ack,
  output logic                vid_rvalid,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic                vid_late,
  input  logic                aux_req,
  input  logic                aux_we,
  input  logic [ADDR_W-1:0]   aux_addr,
  input  logic [DATA_W/8-1:0] aux_be,
  input  logic [DATA_W-1:0]   aux_wdata,
  output logic                aux_ack,
  output logic                aux_rvalid,
  output logic [DATA_W-1:0]   aux_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= MAX_CNT) return MAX_CNT;
    return v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] starve_cnt;
  logic             force_aux;
  logic             gnt_vid;
  logic             gnt_aux;
  logic             rd_vid_p1;
  logic             rd_aux_p1;

  // Stage 0: combinational grant. Raw grants feed the flops (held in reset anyway);
  // the resetn-gated versions drive the outputs.
  always_comb begin
    force_aux = aux_req && (starve_cnt == MAX_CNT);
    gnt_vid   = 1'b0;
    gnt_aux   = 1'b0;
    if (force_aux)    gnt_aux = 1'b1;
    else if (vid_req) gnt_vid = 1'b1;
    else if (aux_req) gnt_aux = 1'b1;
  end

  always_comb begin
    vid_ack   = gnt_vid && resetn;
    aux_ack   = gnt_aux && resetn;
    vid_late  = vid_req && force_aux && resetn;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    if (vid_ack) begin
      mem_addr = vid_addr;
    end else if (aux_ack) begin
      mem_addr  = aux_addr;
      mem_we    = aux_we;
      mem_be    = aux_we ? aux_be : {BE_W{1'b0}};
      mem_wdata = aux_wdata;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!aux_req || gnt_aux) begin
      starve_cnt <= '0;
    end else if (gnt_vid) begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Stage 1: read return, one cycle after the accepting ack.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rd_vid_p1 <= 1'b0;
      rd_aux_p1 <= 1'b0;
    end else begin
      rd_vid_p1 <= gnt_vid;
      rd_aux_p1 <= gnt_aux && !aux_we;
    end
  end

  assign vid_rvalid = rd_vid_p1;
  assign aux_rvalid = rd_aux_p1;
  assign vid_rdata  = mem_rdata;
  assign aux_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed self-checking bench for vram_port_arbiter with a 1-cycle-latency block RAM model.
module tb_vram_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                CLOCK_50;
  logic                resetn;
  logic                vid_req;
  logic [ADDR_W-1:0]   vid_addr;
  logic                vid_ack;
  logic                vid_rvalid;
  logic [DATA_W-1:0]   vid_rdata;
  logic                vid_late;
  logic                aux_req;
  logic                aux_we;
  logic [ADDR_W-1:0]   aux_addr;
  logic [DATA_W/8-1:0] aux_be;
  logic [DATA_W-1:0]   aux_wdata;
  logic                aux_ack;
  logic                aux_rvalid;
  logic [DATA_W-1:0]   aux_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  int total = 0;
  int bad   = 0;

  vram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(8)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata), .vid_late(vid_late),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_be(aux_be),
    .aux_wdata(aux_wdata), .aux_ack(aux_ack), .aux_rvalid(aux_rvalid),
    .aux_rdata(aux_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Block RAM read port: data for the presented address appears the next cycle.
  always @(posedge CLOCK_50) mem_rdata <= mem_val(mem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_vid;
    logic [ADDR_W-1:0] prev_addr;
    resetn = 1'b0; vid_req = 1'b1; vid_addr = 32'h40;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h80; aux_be = 4'hF; aux_wdata = 32'h0;

    // Reset held with both requests pending
    repeat (3) tick();
    #5;
    check("rst_vid_ack", vid_ack, 0);
    check("rst_aux_ack", aux_ack, 0);
    check("rst_vid_rvalid", vid_rvalid, 0);
    check("rst_aux_rvalid", aux_rvalid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_vid_late", vid_late, 0);
    tick(); resetn = 1'b1; #5;
    check("rel_vid_ack", vid_ack, 1);
    check("rel_aux_ack", aux_ack, 0);
    check("rel_mem_addr", mem_addr, 32'h40);
    tick(); vid_req = 1'b0; aux_req = 1'b0; #5;
    check("rel_vid_rvalid", vid_rvalid, 1);
    check("idle_mem_addr", mem_addr, 0);
    tick(); #5;

    // Video-only read
    tick(); vid_req = 1'b1; vid_addr = 32'h40; #5;
    check("vr_ack", vid_ack, 1);
    check("vr_mem_addr", mem_addr, 32'h40);
    check("vr_mem_we", mem_we, 0);
    tick(); vid_req = 1'b0; #5;
    check("vr_rvalid", vid_rvalid, 1);
    check("vr_rdata", vid_rdata, 32'hDEADBEEF);
    check("vr_aux_rvalid", aux_rvalid, 0);

    // Aux write
    tick(); aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h10; aux_be = 4'b0011; aux_wdata = 32'h12345678; #5;
    check("aw_ack", aux_ack, 1);
    check("aw_vid_ack", vid_ack, 0);
    check("aw_mem_we", mem_we, 1);
    check("aw_mem_be", mem_be, 4'b0011);
    check("aw_mem_addr", mem_addr, 32'h10);
    check("aw_mem_wdata", mem_wdata, 32'h12345678);
    tick(); aux_req = 1'b0; aux_we = 1'b0; #5;
    check("aw_no_rvalid", aux_rvalid, 0);
    check("aw_idle_we", mem_we, 0);

    // Aux read: byte enables masked
    tick(); aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h20; aux_be = 4'hF; #5;
    check("ar_ack", aux_ack, 1);
    check("ar_mem_be", mem_be, 0);
    check("ar_mem_we", mem_we, 0);
    tick(); aux_req = 1'b0; #5;
    check("ar_rvalid", aux_rvalid, 1);
    check("ar_rdata", aux_rdata, mem_val(32'h20));
    check("ar_vid_rvalid", vid_rvalid, 0);

    // Starvation: 8 video wins then a forced aux slot
    tick(); vid_req = 1'b1; vid_addr = 32'h44; aux_req = 1'b1; aux_addr = 32'h80; #5;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) begin tick(); #5; end
      check($sformatf("sv_vid_ack%0d", i), vid_ack, 1);
      check($sformatf("sv_aux_ack%0d", i), aux_ack, 0);
      check($sformatf("sv_late%0d", i), vid_late, 0);
    end
    tick(); #5;
    check("sv_force_aux", aux_ack, 1);
    check("sv_force_vid", vid_ack, 0);
    check("sv_force_late", vid_late, 1);
    check("sv_force_addr", mem_addr, 32'h80);
    check("sv_force_vrv", vid_rvalid, 1);
    tick(); #5;
    check("sv_resume_vid", vid_ack, 1);
    check("sv_resume_aux", aux_ack, 0);
    check("sv_resume_late", vid_late, 0);
    check("sv_aux_rvalid", aux_rvalid, 1);
    check("sv_aux_rdata", aux_rdata, mem_val(32'h80));
    check("sv_vid_rvalid", vid_rvalid, 0);

    // Abandon: aux drops for one cycle, the count restarts from zero
    tick(); aux_req = 1'b0; #5;
    check("ab_vid_ack", vid_ack, 1);
    tick(); aux_req = 1'b1; #5;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) begin tick(); #5; end
      check($sformatf("ab_aux_ack%0d", i), aux_ack, 0);
    end
    tick(); #5;
    check("ab_force_aux", aux_ack, 1);
    tick(); vid_req = 1'b0; aux_req = 1'b0; #5;
    tick(); #5;

    // Interleaved video/aux reads
    prev_vid = 1'b0; prev_addr = '0;
    for (int i = 0; i < 6; i++) begin
      logic is_vid;
      logic [ADDR_W-1:0] a;
      is_vid = (i % 2 == 0);
      a = is_vid ? (32'h100 + 32'(i * 4)) : (32'h200 + 32'(i * 4));
      tick();
      vid_req = is_vid; vid_addr = a; aux_req = !is_vid; aux_we = 1'b0; aux_addr = a;
      #5;
      check($sformatf("il_vid_ack%0d", i), vid_ack, is_vid);
      check($sformatf("il_aux_ack%0d", i), aux_ack, !is_vid);
      check($sformatf("il_addr%0d", i), mem_addr, a);
      if (i > 0) begin
        check($sformatf("il_vrv%0d", i), vid_rvalid, prev_vid);
        check($sformatf("il_arv%0d", i), aux_rvalid, !prev_vid);
        check($sformatf("il_data%0d", i), prev_vid ? vid_rdata : aux_rdata, mem_val(prev_addr));
      end
      prev_vid = is_vid; prev_addr = a;
    end
    tick(); vid_req = 1'b0; aux_req = 1'b0; #5;
    check("il_last_arv", aux_rvalid, 1);
    check("il_last_vrv", vid_rvalid, 0);
    check("il_last_data", aux_rdata, mem_val(prev_addr));
    tick(); #5;
    check("il_idle_vrv", vid_rvalid, 0);
    check("il_idle_arv", aux_rvalid, 0);

    // Reset mid-read: the pending video return is dropped
    tick(); vid_req = 1'b1; vid_addr = 32'h40; #5;
    check("mr_ack", vid_ack, 1);
    #4; resetn = 1'b0; vid_req = 1'b0;
    tick(); #5;
    check("mr_rvalid0", vid_rvalid, 0);
    tick(); #5;
    check("mr_rvalid1", vid_rvalid, 0);
    tick(); resetn = 1'b1; #5;
    check("mr_rvalid_rel", vid_rvalid, 0);
    tick(); #5;
    check("mr_rvalid_after", vid_rvalid, 0);
    tick(); vid_req = 1'b1; aux_req = 1'b1; aux_addr = 32'h80; #5;
    check("mr_first_vid", vid_ack, 1);
    check("mr_first_aux", aux_ack, 0);
    tick(); vid_req = 1'b0; aux_req = 1'b0; #5;
    check("mr_first_rvalid", vid_rvalid, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
